fp2int_seq_cvt: RTL and testbench

Multi-cycle FP32→INT32 converter implementing RISC-V FCVT.W.S / FCVT.WU.S semantics: all five rounding modes, saturation, and NV/NX exception flags. It sits beside the combinational int/float converter in the FP execute path and takes over the float→int direction wherever correct rounding and flag reporting are required. A valid/ready handshake connects it to issue and writeback. Alignment runs one bit per cycle by default, or in a single cycle when configured.

---
 rtl/fp2int_seq_cvt.sv | 252 +++++++++++++++++++++++++
 tb/tb_fp2int_seq_cvt.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fp2int_seq_cvt.sv
// FP32 -> INT32/UINT32 converter (FCVT.W.S / FCVT.WU.S) with all RISC-V rounding modes and NV/NX flags.
// Alignment is serial (1 bit/cycle) unless FCVT_FAST_SHIFT_EN selects a single-cycle barrel shift.
module fp2int_seq_cvt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic [4:0]  fflags
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic        sign_q, sign_d;
  logic        uns_q, uns_d;
  logic        left_q, left_d;
  logic [2:0]  rm_q, rm_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] int_out_q, int_out_d;
  logic [4:0]  fflags_q, fflags_d;
`ifdef FCVT_FAST_SHIFT_EN
  logic        aligned_q, aligned_d;
  logic [63:0] wide_s;
`endif

  logic        is_nan_s, is_big_s, is_zero_s;
  logic signed [9:0] e_s, diff_s;
  logic        inc_s, inexact_s, nv_s;
  logic [32:0] m33_s;
  logic [31:0] res_s;

  // Operand classification and rounding/range datapath.
  always_comb begin
    is_nan_s  = (fp_in[30:23] == 8'hFF) && (fp_in[22:0] != 23'd0);
    is_big_s  = (fp_in[30:23] >= 8'd159);
    is_zero_s = (fp_in[30:0] == 31'd0);
    if (fp_in[30:23] == 8'd0) begin
      e_s = -10'sd126;
    end else begin
      e_s = $signed({2'b00, fp_in[30:23]}) - 10'sd127;
    end
    diff_s = 10'sd23 - e_s;

    inexact_s = guard_q | sticky_q;
    case (rm_q)
      3'd1:    inc_s = 1'b0;
      3'd2:    inc_s = sign_q & inexact_s;
      3'd3:    inc_s = ~sign_q & inexact_s;
      3'd4:    inc_s = guard_q;
      default: inc_s = guard_q & (sticky_q | mag_q[0]);
    endcase
    m33_s = {1'b0, mag_q} + {32'd0, inc_s};

    nv_s  = 1'b0;
    res_s = m33_s[31:0];
    if (!uns_q) begin
      if (!sign_q && (m33_s > 33'h0_7FFF_FFFF)) begin
        res_s = 32'h7FFF_FFFF;
        nv_s  = 1'b1;
      end else if (sign_q && (m33_s > 33'h0_8000_0000)) begin
        res_s = 32'h8000_0000;
        nv_s  = 1'b1;
      end else if (sign_q) begin
        res_s = 32'd0 - m33_s[31:0];
      end else begin
        res_s = m33_s[31:0];
      end
    end else begin
      if (sign_q && (m33_s != 33'd0)) begin
        res_s = 32'd0;
        nv_s  = 1'b1;
      end else if (sign_q) begin
        res_s = 32'd0;
      end else if (m33_s > 33'h0_FFFF_FFFF) begin
        res_s = 32'hFFFF_FFFF;
        nv_s  = 1'b1;
      end else begin
        res_s = m33_s[31:0];
      end
    end
  end

  // Next-state logic for the conversion sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    sign_d      = sign_q;
    uns_d       = uns_q;
    left_d      = left_q;
    rm_d        = rm_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    int_out_d   = int_out_q;
    fflags_d    = fflags_q;
`ifdef FCVT_FAST_SHIFT_EN
    aligned_d   = aligned_q;
    wide_s      = {mag_q, 32'd0} >> cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          sign_d     = fp_in[31];
          uns_d      = is_unsigned;
          rm_d       = rm;
          guard_d    = 1'b0;
          sticky_d   = 1'b0;
          mag_d      = {8'd0, (fp_in[30:23] != 8'd0), fp_in[22:0]};
          left_d     = (e_s >= 10'sd23);
          if (e_s >= 10'sd23) begin
            cnt_d = 5'(e_s - 10'sd23);
          end else begin
            cnt_d = (diff_s > 10'sd25) ? 5'd25 : 5'(diff_s);
          end
`ifdef FCVT_FAST_SHIFT_EN
          aligned_d = 1'b0;
`endif
          // Specials enter DONE with out_valid still low; DONE raises it next cycle.
          if (is_nan_s) begin
            state_d   = DONE;
            int_out_d = is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            fflags_d  = 5'b10000;
          end else if (is_big_s) begin
            state_d   = DONE;
            fflags_d  = 5'b10000;
            if (!fp_in[31]) begin
              int_out_d = is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            end else begin
              int_out_d = is_unsigned ? 32'h0000_0000 : 32'h8000_0000;
            end
          end else if (is_zero_s) begin
            state_d   = DONE;
            int_out_d = 32'd0;
            fflags_d  = 5'b00000;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SHIFT: begin
`ifdef FCVT_FAST_SHIFT_EN
        if (!aligned_q) begin
          aligned_d = 1'b1;
          if (left_q) begin
            mag_d = mag_q << cnt_q;
          end else begin
            mag_d    = wide_s[63:32];
            guard_d  = wide_s[31];
            sticky_d = |wide_s[30:0];
          end
        end else begin
          state_d = ROUND;
        end
`else
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          if (left_q) begin
            mag_d = {mag_q[30:0], 1'b0};
          end else begin
            mag_d    = {1'b0, mag_q[31:1]};
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
          end
        end else begin
          state_d = ROUND;
        end
`endif
      end
      ROUND: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        int_out_d   = res_s;
        fflags_d    = {nv_s, 3'b000, ~nv_s & inexact_s};
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      mag_q       <= 32'd0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      uns_q       <= 1'b0;
      left_q      <= 1'b0;
      rm_q        <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      int_out_q   <= 32'd0;
      fflags_q    <= 5'd0;
`ifdef FCVT_FAST_SHIFT_EN
      aligned_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      sign_q      <= sign_d;
      uns_q       <= uns_d;
      left_q      <= left_d;
      rm_q        <= rm_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      int_out_q   <= int_out_d;
      fflags_q    <= fflags_d;
`ifdef FCVT_FAST_SHIFT_EN
      aligned_q   <= aligned_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign int_out   = int_out_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_fp2int_seq_cvt.sv
// Directed scoreboard bench for fp2int_seq_cvt: results, flags, latency, backpressure and reset.
module tb_fp2int_seq_cvt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        is_unsigned;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic [4:0]  fflags;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fp2int_seq_cvt dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_in(fp_in), .is_unsigned(is_unsigned), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready), .int_out(int_out), .fflags(fflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Edges from accept to out_valid, derived from the operand.
  function automatic int lat_model(input logic [31:0] f);
    int e;
    int n;
    if (f[30:23] >= 8'd159 || f[30:0] == 31'd0) return 1;
`ifdef FCVT_FAST_SHIFT_EN
    e = 0;
    n = 1;
    return e + n + 2;
`else
    e = (f[30:23] == 8'd0) ? -126 : int'({24'd0, f[30:23]}) - 127;
    n = (e >= 23) ? e - 23 : ((23 - e > 25) ? 25 : 23 - e);
    return n + 2;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [31:0] f, input logic uns,
                        input logic [2:0] r, input logic [31:0] eres, input logic [4:0] eflg,
                        input int hold);
    exp_t item;
    int   lat;
    int   elat;
    exp_q.push_back('{res: eres, flg: eflg});
    elat = lat_model(f);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    fp_in = f; is_unsigned = uns; rm = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fp_in = $urandom;
    is_unsigned = ~uns;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    item = exp_q.pop_front();
    chk({tag, "_int_out"}, int_out, item.res);
    chk({tag, "_fflags"}, {27'd0, fflags}, {27'd0, item.flg});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      fp_in = 32'h4B00_0000 + 32'(h);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_int"}, int_out, item.res);
      chk({tag, "_hold_flags"}, {27'd0, fflags}, {27'd0, item.flg});
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; fp_in = 32'd0; is_unsigned = 1'b0; rm = 3'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_int_out", int_out, 32'd0);
    chk("rst_fflags", {27'd0, fflags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("pi_rne",     32'h4049_0FDB, 1'b0, 3'd0, 32'd3,          5'h01, 0);
    run_op("p2_5_rne",   32'h4020_0000, 1'b0, 3'd0, 32'd2,          5'h01, 0);
    run_op("p2_5_rmm",   32'h4020_0000, 1'b0, 3'd4, 32'd3,          5'h01, 0);
    run_op("p2_5_rm5",   32'h4020_0000, 1'b0, 3'd5, 32'd2,          5'h01, 0);
    run_op("p3_5_rne",   32'h4060_0000, 1'b0, 3'd0, 32'd4,          5'h01, 0);
    run_op("m2_5_rdn",   32'hC020_0000, 1'b0, 3'd2, 32'hFFFF_FFFD,  5'h01, 0);
    run_op("one_rtz",    32'h3F80_0000, 1'b0, 3'd1, 32'd1,          5'h00, 0);
    run_op("big_s",      32'h4EFF_FFFF, 1'b0, 3'd0, 32'h7FFF_FF80,  5'h00, 0);
    run_op("p2_31_s",    32'h4F00_0000, 1'b0, 3'd0, 32'h7FFF_FFFF,  5'h10, 0);
    run_op("m2_31_s",    32'hCF00_0000, 1'b0, 3'd0, 32'h8000_0000,  5'h00, 0);
    run_op("p2_32_u",    32'h4F80_0000, 1'b1, 3'd0, 32'hFFFF_FFFF,  5'h10, 0);
    run_op("nan_u",      32'h7FC0_0000, 1'b1, 3'd0, 32'hFFFF_FFFF,  5'h10, 0);
    run_op("minf_s",     32'hFF80_0000, 1'b0, 3'd0, 32'h8000_0000,  5'h10, 0);
    run_op("zero",       32'h0000_0000, 1'b0, 3'd3, 32'd0,          5'h00, 0);
    run_op("m0_3_u_rtz", 32'hBE99_999A, 1'b1, 3'd1, 32'd0,          5'h01, 0);
    run_op("m1_u",       32'hBF80_0000, 1'b1, 3'd0, 32'd0,          5'h10, 0);
    run_op("subn_rup",   32'h0000_0001, 1'b0, 3'd3, 32'd1,          5'h01, 0);
    run_op("pi_hold",    32'h4049_0FDB, 1'b0, 3'd0, 32'd3,          5'h01, 5);

    // Reset during SHIFT discards the operation and clears outputs.
    fp_in = 32'h3F80_0000; is_unsigned = 1'b0; rm = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_int_out", int_out, 32'd0);
    chk("midrst_fflags", {27'd0, fflags}, 32'd0);

    run_op("after_rst",  32'hC020_0000, 1'b0, 3'd3, 32'hFFFF_FFFE,  5'h01, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
